// File: rtl/weights_addr_sequencer.sv
// Weight-ROM address sequencer: one pass of addresses 0..NB_WEIGHTS-1 per neuron, framed by sow/eow.
// Optional feature macro WSEQ_FLAT_ADDR_EN: flat addressing n*NB_WEIGHTS + w across all neurons.
module weights_addr_sequencer #(
  parameter int NB_WEIGHTS   = 784,
  parameter int NB_NEURONS   = 16,
`ifdef WSEQ_FLAT_ADDR_EN
  parameter int ADDR_WIDTH   = (NB_WEIGHTS * NB_NEURONS > 1) ? $clog2(NB_WEIGHTS * NB_NEURONS) : 1,
`else
  parameter int ADDR_WIDTH   = (NB_WEIGHTS > 1) ? $clog2(NB_WEIGHTS) : 1,
`endif
  parameter int NEURON_WIDTH = (NB_NEURONS > 1) ? $clog2(NB_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    rtr_i,
  output logic                    rts_o,
  output logic                    sow_o,
  output logic                    eow_o,
  output logic [ADDR_WIDTH-1:0]   address_o,
  output logic [NEURON_WIDTH-1:0] neuron_o
);

  localparam int W_WIDTH = (NB_WEIGHTS > 1) ? $clog2(NB_WEIGHTS) : 1;

  localparam logic [W_WIDTH-1:0]      W_LAST = W_WIDTH'(NB_WEIGHTS - 1);
  localparam logic [NEURON_WIDTH-1:0] N_LAST = NEURON_WIDTH'(NB_NEURONS - 1);

  // Handshake: a beat transfers on a rising edge where rts_o & rtr_i; while rts_o is
  // high and rtr_i low, every output holds its value.
  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [W_WIDTH-1:0]      w_q, w_d;
  logic [NEURON_WIDTH-1:0] n_q, n_d;
  logic                    done_q, done_d;
  logic                    w_last, n_last;

`ifdef WSEQ_FLAT_ADDR_EN
  localparam logic [ADDR_WIDTH-1:0] BASE_STEP = ADDR_WIDTH'(NB_WEIGHTS);

  // base_q holds n*NB_WEIGHTS; addr_q tracks base_q + w_q without an adder on the output.
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`endif

  assign w_last = (w_q == W_LAST);
  assign n_last = (n_q == N_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
`ifdef WSEQ_FLAT_ADDR_EN
      base_q  <= '0;
      addr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      n_q     <= n_d;
      done_q  <= done_d;
`ifdef WSEQ_FLAT_ADDR_EN
      base_q  <= base_d;
      addr_q  <= addr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    n_d     = n_q;
    done_d  = 1'b0;
`ifdef WSEQ_FLAT_ADDR_EN
    base_d  = base_q;
    addr_d  = addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          w_d     = '0;
          n_d     = '0;
`ifdef WSEQ_FLAT_ADDR_EN
          base_d  = '0;
          addr_d  = '0;
`endif
        end
      end
      RUN: begin
        if (rtr_i) begin
          if (!w_last) begin
            w_d = w_q + W_WIDTH'(1);
`ifdef WSEQ_FLAT_ADDR_EN
            addr_d = addr_q + ADDR_WIDTH'(1);
`endif
          end else begin
            w_d = '0;
            if (!n_last) begin
              n_d = n_q + NEURON_WIDTH'(1);
`ifdef WSEQ_FLAT_ADDR_EN
              base_d = base_q + BASE_STEP;
              addr_d = base_q + BASE_STEP;
`endif
            end else begin
              // Final beat of the sweep: counters return to their idle values.
              state_d = IDLE;
              n_d     = '0;
              done_d  = 1'b1;
`ifdef WSEQ_FLAT_ADDR_EN
              base_d  = '0;
              addr_d  = '0;
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rts_o    = (state_q == RUN);
  assign busy_o   = (state_q == RUN);
  assign done_o   = done_q;
  assign sow_o    = (state_q == RUN) && (w_q == '0);
  assign eow_o    = (state_q == RUN) && w_last;
  assign neuron_o = n_q;
`ifdef WSEQ_FLAT_ADDR_EN
  assign address_o = addr_q;
`else
  assign address_o = ADDR_WIDTH'(w_q);
`endif

endmodule

// File: tb/tb_weights_addr_sequencer.sv
// Bench for weights_addr_sequencer: three instances (4x2, 4x3, 1x3) checked with vectors and beat queues.
module tb_weights_addr_sequencer;

`ifdef WSEQ_FLAT_ADDR_EN
  localparam int A_AW = 3;
  localparam int B_AW = 4;
  localparam int C_AW = 2;
`else
  localparam int A_AW = 2;
  localparam int B_AW = 2;
  localparam int C_AW = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic a_start, a_rtr, a_busy, a_done, a_rts, a_sow, a_eow;
  logic [A_AW-1:0] a_addr;
  logic [0:0]      a_neuron;
  logic b_start, b_rtr, b_busy, b_done, b_rts, b_sow, b_eow;
  logic [B_AW-1:0] b_addr;
  logic [1:0]      b_neuron;
  logic c_start, c_rtr, c_busy, c_done, c_rts, c_sow, c_eow;
  logic [C_AW-1:0] c_addr;
  logic [1:0]      c_neuron;

  weights_addr_sequencer #(.NB_WEIGHTS(4), .NB_NEURONS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
    .rtr_i(a_rtr), .rts_o(a_rts), .sow_o(a_sow), .eow_o(a_eow),
    .address_o(a_addr), .neuron_o(a_neuron));

  weights_addr_sequencer #(.NB_WEIGHTS(4), .NB_NEURONS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .rtr_i(b_rtr), .rts_o(b_rts), .sow_o(b_sow), .eow_o(b_eow),
    .address_o(b_addr), .neuron_o(b_neuron));

  weights_addr_sequencer #(.NB_WEIGHTS(1), .NB_NEURONS(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .start_i(c_start), .busy_o(c_busy), .done_o(c_done),
    .rtr_i(c_rtr), .rts_o(c_rts), .sow_o(c_sow), .eow_o(c_eow),
    .address_o(c_addr), .neuron_o(c_neuron));

  int tests = 0;
  int fails = 0;

  typedef logic [17:0] beat_t;
  beat_t a_got[$], b_got[$], c_got[$], got_q[$], exp_q[$];
  int a_dones = 0, b_dones = 0, c_dones = 0;

  typedef struct {
    logic start, rtr;
    logic rts, sow, eow, busy, done;
    int   w, n;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t pack(input logic sow, input logic eow, input logic [31:0] n,
                                 input logic [31:0] a);
    return {sow, eow, n[3:0], a[11:0]};
  endfunction

  function automatic int exp_addr(input int w, input int n, input int nw);
`ifdef WSEQ_FLAT_ADDR_EN
    return n * nw + w;
`else
    return w;
`endif
  endfunction

  function automatic void build(input int nw, input int nn);
    for (int n = 0; n < nn; n++)
      for (int w = 0; w < nw; w++)
        exp_q.push_back(pack(w == 0, w == nw - 1, n, exp_addr(w, n, nw)));
  endfunction

  function automatic void add(input logic s, input logic r, input logic rts, input logic sow,
                              input logic eow, input logic busy, input logic done,
                              input int w, input int n);
    vec_t v;
    v.start = s; v.rtr = r; v.rts = rts; v.sow = sow; v.eow = eow;
    v.busy = busy; v.done = done; v.w = w; v.n = n;
    vecs.push_back(v);
  endfunction

  task automatic compare_q(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
  endtask

  // Accepted beats are captured at the falling edge; a stalled beat must be unchanged one cycle later.
  logic  a_hold = 1'b0, b_hold = 1'b0;
  beat_t a_prev, b_prev;

  always @(negedge clk) begin
    beat_t cur;
    if (!rst_n) begin
      a_hold = 1'b0;
    end else begin
      cur = pack(a_sow, a_eow, 32'(a_neuron), 32'(a_addr));
      if (a_hold) begin
        check("a_stall_rts", 32'(a_rts), 32'd1);
        check("a_stall_beat", cur, a_prev);
      end
      if (a_rts && a_rtr) a_got.push_back(cur);
      if (a_done) a_dones++;
      a_hold = a_rts && !a_rtr;
      a_prev = cur;
    end
  end

  always @(negedge clk) begin
    beat_t cur;
    if (!rst_n) begin
      b_hold = 1'b0;
    end else begin
      cur = pack(b_sow, b_eow, 32'(b_neuron), 32'(b_addr));
      if (b_hold) begin
        check("b_stall_rts", 32'(b_rts), 32'd1);
        check("b_stall_beat", cur, b_prev);
      end
      if (b_rts && b_rtr) b_got.push_back(cur);
      if (b_done) b_dones++;
      b_hold = b_rts && !b_rtr;
      b_prev = cur;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (c_rts && c_rtr) c_got.push_back(pack(c_sow, c_eow, 32'(c_neuron), 32'(c_addr)));
      if (c_done) c_dones++;
    end
  end

  function automatic logic [31:0] a_outs();
    return {15'd0, a_busy, a_done, a_rts, a_sow, a_eow, 4'(a_neuron), 8'(a_addr)};
  endfunction

  initial begin
    int cyc;
    rst_n = 1'b0;
    {a_start, a_rtr, b_start, b_rtr, c_start, c_rtr} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("a_reset", a_outs(), 32'd0);
    check("b_reset", {b_busy, b_done, b_rts, b_sow, b_eow, 4'(b_neuron), 8'(b_addr)}, 32'd0);
    check("c_reset", {c_busy, c_done, c_rts, c_sow, c_eow, 4'(c_neuron), 8'(c_addr)}, 32'd0);
    rst_n = 1'b1;

    // start rtr | rts sow eow busy done | w n
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0, 2, 0);
    add(0, 0, 1, 0, 0, 1, 0, 2, 0);
    add(1, 1, 1, 0, 1, 1, 0, 3, 0);
    add(0, 0, 1, 0, 1, 1, 0, 3, 0);
    add(0, 1, 1, 1, 0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 0, 1, 0, 1, 1);
    add(0, 0, 1, 0, 0, 1, 0, 1, 1);
    add(0, 1, 1, 0, 0, 1, 0, 2, 1);
    add(0, 1, 1, 0, 1, 1, 0, 3, 1);
    add(0, 0, 1, 0, 1, 1, 0, 3, 1);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      a_start = vecs[i].start;
      a_rtr   = vecs[i].rtr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_outs", i), a_outs(),
            {15'd0, vecs[i].busy, vecs[i].done, vecs[i].rts, vecs[i].sow, vecs[i].eow,
             4'(vecs[i].n), 8'(exp_addr(vecs[i].w, vecs[i].n, 4))});
    end
    got_q = a_got;
    exp_q.delete();
    build(4, 2);
    exp_q.push_back(pack(1, 0, 0, 0));
    compare_q("a_table_beats");

    // Asynchronous reset in the middle of the re-started sweep.
    rst_n = 1'b0;
    #2;
    check("a_async_reset", a_outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_got.delete();
    a_dones = 0;

    // Five beats at full rate, then reset: no done, nothing more accepted.
    a_start = 1'b1;
    a_rtr   = 1'b1;
    @(posedge clk);
    #1;
    check("a_first_beat", a_outs(), {15'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0});
    a_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("a_reset_after5", a_outs(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_no_done", a_dones, 0);
    check("a_reset_beats", a_got.size(), 5);
    rst_n = 1'b1;
    a_got.delete();

    // Full-rate sweep with a start pulse mid-sweep that must be ignored.
    a_start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    while (!a_done && cyc < 100) begin
      a_start = (cyc == 3);
      @(posedge clk);
      #1;
      cyc++;
    end
    a_start = 1'b0;
    check("a_sweep_cycles", cyc, 8);
    check("a_done_idle", {a_busy, a_rts}, 2'b00);
    @(posedge clk);
    #1;
    check("a_done_one_cycle", a_done, 1'b0);
    check("a_done_count", a_dones, 1);
    check("a_stays_idle", a_rts, 1'b0);
    got_q = a_got;
    exp_q.delete();
    build(4, 2);
    compare_q("a_full_beats");

    // Random back-pressure on the 4x3 instance.
    b_start = 1'b1;
    b_rtr   = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    b_start = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 400) begin
      b_rtr = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cyc++;
    end
    check("b_done_seen", b_done, 1'b1);
    @(posedge clk);
    #1;
    check("b_done_count", b_dones, 1);
    got_q = b_got;
    exp_q.delete();
    build(4, 3);
    compare_q("b_beats");

    // Single-weight passes: every beat carries sow and eow.
    c_start = 1'b1;
    c_rtr   = 1'b1;
    @(posedge clk);
    #1;
    c_start = 1'b0;
    cyc = 0;
    while (!c_done && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("c_sweep_cycles", cyc, 3);
    @(posedge clk);
    #1;
    check("c_done_count", c_dones, 1);
    got_q = c_got;
    exp_q.delete();
    build(1, 3);
    compare_q("c_beats");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weights_addr_sequencer.md
# weights_addr_sequencer

Address-stream controller that drives the slave side of the weights ROM: on a start command it emits, for each neuron of a layer, one pass of weight addresses 0..NB_WEIGHTS-1, framed with sow/eow, over the rts/rtr handshake. It sits between the layer control logic and the weights ROM. It replaces ad-hoc address counters so that one ROM can be swept once per neuron with correct back-pressure handling.

## Interface
- NB_WEIGHTS, 784: weights per neuron (addresses per pass), ≥1
- NB_NEURONS, 16: passes per start command, ≥1
- ADDR_WIDTH, log2(NB_WEIGHTS) (posit_defines), or log2(NB_WEIGHTS*NB_NEURONS) with WSEQ_FLAT_ADDR_EN: address port width

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  start one layer sweep; sampled only in IDLE
- busy_o  output  1  high in RUN
- done_o  output  1  one-cycle pulse after the final beat is accepted
- rtr_i  input  1  downstream (ROM `rtr_o`) ready to receive
- rts_o  output  1  address beat valid
- sow_o  output  1  first beat of a pass
- eow_o  output  1  last beat of a pass
- address_o  output  ADDR_WIDTH  weight address
- neuron_o  output  log2(NB_NEURONS)  index of current pass

## Operation
- States: IDLE, RUN.
- IDLE: rts_o=0. start_i=1 → RUN, weight counter w=0, neuron counter n=0.
- RUN: rts_o=1 continuously. A transfer occurs when rts_o & rtr_i.
- On transfer: if w<NB_WEIGHTS-1, then w←w+1. Otherwise w←0. Then, if n<NB_NEURONS-1, n←n+1. Otherwise this is the final beat → IDLE, done_o=1 for the next cycle.
- No transfer: all outputs hold their values (address, sow, eow, neuron stable while rts_o & ~rtr_i).
- sow_o = (w==0) & rts_o. eow_o = (w==NB_WEIGHTS-1) & rts_o. NB_WEIGHTS=1 → sow_o and eow_o are both set on every beat.
- address_o = w (zero when IDLE). neuron_o = n.
- start_i in RUN: ignored, no restart, no queueing.
- Counters never exceed their bounds. There is no wrap-around inside a sweep except w→0 at a pass boundary.

## Timing
- All outputs registered. Reset values: busy_o=0, done_o=0, rts_o=0, sow_o=0, eow_o=0, address_o=0, neuron_o=0.
- start_i high at edge t → rts_o=1, sow_o=1, address_o=0, busy_o=1 after edge t.
- With rtr_i held high: one beat per cycle. A full sweep takes NB_WEIGHTS*NB_NEURONS cycles from the first rts_o.
- Final beat accepted at edge t → after edge t: rts_o=0, busy_o=0, done_o=1. After edge t+1: done_o=0.
- start_i high during the done_o cycle is accepted, because the block is in IDLE. A new sweep starts after that edge.
- rtr_i is combinationally used only to gate counter enables. There is no combinational path from any input to any output.
- rst_n low at any time, including mid-sweep: immediately return to IDLE with reset values. The partially emitted pass is abandoned and there is no done_o.

## Configuration
- WSEQ_FLAT_ADDR_EN defined: the ROM holds all neurons back to back. address_o = n*NB_WEIGHTS + w, with width log2(NB_WEIGHTS*NB_NEURONS). Implement with an incrementing base register (+NB_WEIGHTS per pass), not a multiplier.
- WSEQ_FLAT_ADDR_EN undefined: address_o = w, width log2(NB_WEIGHTS). The same per-neuron window is re-read each pass.

## Test plan
- NB_WEIGHTS=4, NB_NEURONS=2, macro off, rtr_i=1, start_i pulse → addresses 0,1,2,3,0,1,2,3 on 8 consecutive cycles. sow on beats 1 and 5, eow on beats 4 and 8, neuron_o 0 then 1. done_o pulse the cycle after beat 8.
- Same sweep with rtr_i toggled pseudo-randomly → identical accepted-beat sequence. Outputs stable on every cycle with rts_o=1, rtr_i=0.
- Macro on, NB_WEIGHTS=4, NB_NEURONS=3 → accepted addresses 0..11 in order. eow on beats with address 3, 7, 11.
- NB_WEIGHTS=1, NB_NEURONS=3 → 3 beats, all with address 0 (macro off), each carrying sow=eow=1.
- start_i pulsed mid-sweep → ignored, total beats unchanged. start_i during the done_o cycle → new sweep, first beat on the next cycle.
- rst_n asserted after beat 5 of 8 → all outputs 0 immediately, no done_o. A new start_i after reset release gives a full 8-beat sweep from address 0.
